// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: reads opcode plus 0-2 operand bytes over a byte bus,
// owns next_pc for the regfile, and hands one assembled instruction to decode.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'hFFFC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] pc,
  output logic [15:0] next_pc,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ready,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic [7:0]  opcode,
  output logic [15:0] operand,
  output logic [1:0]  ins_len
);

  typedef enum logic [1:0] {FETCH_OP, FETCH_LO, FETCH_HI, HOLD} state_t;

  state_t     state, state_nxt;
  logic       accept;
  logic [1:0] len_dec;

  // NMOS 6502 documented-opcode lengths, split by the aaa/bbb/cc opcode fields;
  // anything undocumented (and BRK) falls through to length 1.
  function automatic logic [1:0] op_len(input logic [7:0] op);
    logic [2:0] aaa;
    logic [2:0] bbb;
    logic [1:0] len;
    aaa = op[7:5];
    bbb = op[4:2];
    len = 2'd1;
    case (op[1:0])
      2'b01: begin
        if (op != 8'h89)
          len = (bbb == 3'b011 || bbb == 3'b110 || bbb == 3'b111) ? 2'd3 : 2'd2;
      end
      2'b10: begin
        case (bbb)
          3'b000:         if (aaa == 3'b101) len = 2'd2;
          3'b001, 3'b101: len = 2'd2;
          3'b011:         len = 2'd3;
          3'b111:         if (aaa != 3'b100) len = 2'd3;
          default:        len = 2'd1;
        endcase
      end
      2'b00: begin
        case (bbb)
          3'b000: begin
            if (aaa == 3'b001)      len = 2'd3;
            else if (aaa >= 3'b101) len = 2'd2;
          end
          3'b001:  if (aaa == 3'b001 || aaa >= 3'b100) len = 2'd2;
          3'b011:  if (aaa != 3'b000) len = 2'd3;
          3'b100:  len = 2'd2;
          3'b101:  if (aaa == 3'b100 || aaa == 3'b101) len = 2'd2;
          3'b111:  if (aaa == 3'b101) len = 2'd3;
          default: len = 2'd1;
        endcase
      end
      default: len = 2'd1;
    endcase
    return len;
  endfunction

  assign mem_addr = pc;
  assign mem_rd   = (state != HOLD);
  assign accept   = mem_rd & mem_ready & ~redirect;
  assign len_dec  = op_len(mem_rdata);

  always_comb begin
    next_pc = pc;
    if (!rst_n)        next_pc = RESET_PC;
    else if (redirect) next_pc = redirect_pc;
    else if (accept)   next_pc = pc + 16'd1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH_OP: if (accept) state_nxt = (len_dec == 2'd1) ? HOLD : FETCH_LO;
      FETCH_LO: if (accept) state_nxt = (ins_len == 2'd2) ? HOLD : FETCH_HI;
      FETCH_HI: if (accept) state_nxt = HOLD;
      HOLD:     if (ins_ready) state_nxt = FETCH_OP;
      default:  state_nxt = FETCH_OP;
    endcase
    if (redirect) state_nxt = FETCH_OP;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FETCH_OP;
      ins_valid <= 1'b0;
      opcode    <= '0;
      operand   <= '0;
      ins_len   <= '0;
    end else begin
      state     <= state_nxt;
      ins_valid <= (state_nxt == HOLD);
      if (accept) begin
        case (state)
          FETCH_OP: begin
            opcode  <= mem_rdata;
            operand <= '0;
            ins_len <= len_dec;
          end
          FETCH_LO: operand[7:0]  <= mem_rdata;
          FETCH_HI: operand[15:8] <= mem_rdata;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: models the regfile pc register and a 64 KiB byte memory.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] pc;
  logic [15:0] next_pc;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_rdata;
  logic        mem_ready;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        ins_valid;
  logic        ins_ready;
  logic [7:0]  opcode;
  logic [15:0] operand;
  logic [1:0]  ins_len;

  logic [7:0]  mem [0:65535];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  fetch_unit #(.RESET_PC(16'hFFFC)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .next_pc(next_pc),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .ins_valid(ins_valid), .ins_ready(ins_ready),
    .opcode(opcode), .operand(operand), .ins_len(ins_len)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) pc <= next_pc;

  assign mem_rdata = mem[pc];

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h, expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Decode vectors: opcode, expected length
  logic [7:0] dv_op  [17] = '{8'h00, 8'h20, 8'h02, 8'h89, 8'h9E, 8'hBC, 8'h6C, 8'h24, 8'h44,
                              8'h96, 8'hB0, 8'h0A, 8'h7D, 8'hA2, 8'hFF, 8'h9C, 8'h94};
  logic [1:0] dv_len [17] = '{2'd1, 2'd3, 2'd1, 2'd1, 2'd1, 2'd3, 2'd3, 2'd2, 2'd1,
                              2'd2, 2'd2, 2'd1, 2'd3, 2'd2, 2'd1, 2'd1, 2'd2};

  initial begin
    logic [15:0] exp_opr;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0200] = 8'hA9; mem[16'h0201] = 8'h42;
    mem[16'h0202] = 8'hAD; mem[16'h0203] = 8'h34; mem[16'h0204] = 8'h12;
    mem[16'h0205] = 8'hEA;
    mem[16'h0206] = 8'h4C; mem[16'h0207] = 8'h77; mem[16'h0208] = 8'h66;
    mem[16'h8000] = 8'h18;
    mem[16'hFFFF] = 8'hA9; mem[16'h0000] = 8'h55;

    rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0; ins_ready = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    repeat (3) tick();
    check("rst_next_pc", next_pc, 16'hFFFC);
    check("rst_ins_valid", {15'd0, ins_valid}, 16'd0);
    check("rst_opcode", {8'd0, opcode}, 16'd0);
    check("rst_ins_len", {14'd0, ins_len}, 16'd0);
    redirect = 1'b1; redirect_pc = 16'h1234; #1;
    check("rst_beats_redirect", next_pc, 16'hFFFC);

    // Release reset and redirect straight to 0200
    rst_n = 1'b1; redirect_pc = 16'h0200; #1;
    check("rel_mem_rd", {15'd0, mem_rd}, 16'd1);
    check("rel_redirect_pc", next_pc, 16'h0200);
    tick();
    redirect = 1'b0; #1;
    check("redir_pc", pc, 16'h0200);
    check("mem_addr_eq_pc", mem_addr, 16'h0200);
    check("redir_ins_valid", {15'd0, ins_valid}, 16'd0);
    check("lda_imm_next_pc", next_pc, 16'h0201);
    ins_ready = 1'b0;
    tick();
    check("lda_imm_mid_valid", {15'd0, ins_valid}, 16'd0);
    tick();
    check("lda_imm_valid", {15'd0, ins_valid}, 16'd1);
    check("lda_imm_opcode", {8'd0, opcode}, 16'h00A9);
    check("lda_imm_operand", operand, 16'h0042);
    check("lda_imm_len", {14'd0, ins_len}, 16'd2);
    check("lda_imm_pc", pc, 16'h0202);
    check("hold_mem_rd", {15'd0, mem_rd}, 16'd0);
    check("hold_next_pc", next_pc, 16'h0202);
    ins_ready = 1'b1;
    tick();
    check("bubble_valid", {15'd0, ins_valid}, 16'd0);

    // LDA abs with mem_ready 1,0,1,0,1
    ins_ready = 1'b0;
    tick();
    check("abs_pc1", pc, 16'h0203);
    mem_ready = 1'b0; #1;
    check("abs_stall_next_pc", next_pc, 16'h0203);
    tick();
    check("abs_pc_stall1", pc, 16'h0203);
    mem_ready = 1'b1;
    tick();
    check("abs_pc2", pc, 16'h0204);
    mem_ready = 1'b0;
    tick();
    check("abs_pc_stall2", pc, 16'h0204);
    check("abs_stall_valid", {15'd0, ins_valid}, 16'd0);
    mem_ready = 1'b1;
    tick();
    check("abs_valid", {15'd0, ins_valid}, 16'd1);
    check("abs_opcode", {8'd0, opcode}, 16'h00AD);
    check("abs_operand", operand, 16'h1234);
    check("abs_len", {14'd0, ins_len}, 16'd3);
    check("abs_pc", pc, 16'h0205);

    // NOP held with ins_ready low
    ins_ready = 1'b1;
    tick();
    ins_ready = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      check("nop_valid", {15'd0, ins_valid}, 16'd1);
      check("nop_opcode", {8'd0, opcode}, 16'h00EA);
      check("nop_next_pc", next_pc, 16'h0206);
      tick();
    end
    check("nop_operand", operand, 16'h0000);
    check("nop_len", {14'd0, ins_len}, 16'd1);
    ins_ready = 1'b1;
    tick();
    check("nop_release_valid", {15'd0, ins_valid}, 16'd0);

    // Redirect in FETCH_LO of JMP abs
    tick();
    check("jmp_lo_pc", pc, 16'h0207);
    redirect = 1'b1; redirect_pc = 16'h8000; #1;
    check("jmp_redir_next_pc", next_pc, 16'h8000);
    tick();
    redirect = 1'b0; ins_ready = 1'b0;
    check("jmp_redir_valid", {15'd0, ins_valid}, 16'd0);
    check("jmp_redir_pc", pc, 16'h8000);
    tick();
    check("tgt_valid", {15'd0, ins_valid}, 16'd1);
    check("tgt_opcode", {8'd0, opcode}, 16'h0018);
    check("tgt_operand", operand, 16'h0000);
    check("tgt_len", {14'd0, ins_len}, 16'd1);

    // Handshake coinciding with redirect, then wrap fetch at FFFF
    ins_ready = 1'b1; redirect = 1'b1; redirect_pc = 16'hFFFF;
    tick();
    redirect = 1'b0; ins_ready = 1'b0; #1;
    check("hs_redir_valid", {15'd0, ins_valid}, 16'd0);
    check("wrap_next_pc", next_pc, 16'h0000);
    tick();
    tick();
    check("wrap_valid", {15'd0, ins_valid}, 16'd1);
    check("wrap_opcode", {8'd0, opcode}, 16'h00A9);
    check("wrap_operand", operand, 16'h0055);
    check("wrap_pc", pc, 16'h0001);

    // Length decode table
    for (int v = 0; v < 17; v++) begin
      mem[16'h3000] = dv_op[v]; mem[16'h3001] = 8'h11; mem[16'h3002] = 8'h22;
      ins_ready = 1'b0; redirect = 1'b1; redirect_pc = 16'h3000;
      tick();
      redirect = 1'b0;
      for (int k = 0; k < 6 && !ins_valid; k++) tick();
      exp_opr = (dv_len[v] == 2'd1) ? 16'h0000 : (dv_len[v] == 2'd2) ? 16'h0011 : 16'h2211;
      check($sformatf("dec_valid_%h", dv_op[v]), {15'd0, ins_valid}, 16'd1);
      check($sformatf("dec_len_%h", dv_op[v]), {14'd0, ins_len}, {14'd0, dv_len[v]});
      check($sformatf("dec_operand_%h", dv_op[v]), operand, exp_opr);
      check($sformatf("dec_pc_%h", dv_op[v]), pc, 16'h3000 + {14'd0, dv_len[v]});
    end

    // Asynchronous reset while holding an instruction
    #2 rst_n = 1'b0; #1;
    check("async_valid", {15'd0, ins_valid}, 16'd0);
    check("async_mem_rd", {15'd0, mem_rd}, 16'd1);
    check("async_len", {14'd0, ins_len}, 16'd0);
    check("async_next_pc", next_pc, 16'hFFFC);
    tick();
    rst_n = 1'b1; #1;
    check("restart_pc", pc, 16'hFFFC);
    check("restart_next_pc", next_pc, 16'hFFFD);
    tick();
    check("restart_valid", {15'd0, ins_valid}, 16'd1);
    check("restart_opcode", {8'd0, opcode}, 16'h0000);
    check("restart_len", {14'd0, ins_len}, 16'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
